// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter.
// Optional bounds checking is enabled by defining RAM_ARB_BOUNDS_EN.
package ram_arb_pkg;

    localparam int unsigned RAM_AW    = 16;
    localparam int unsigned RAM_DW    = 32;
    localparam int unsigned RAM_DEPTH = 37500;
    localparam int unsigned MAX_REQ   = 8;

    typedef enum logic {OP_READ, OP_WRITE} ram_op_t;

    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx |= 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with per-requester grant lock.
// Owns the last-grant pointer and the lock owner.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    output logic [NREQ-1:0]          grant,
    output logic [$clog2(NREQ)-1:0]  grant_idx,
    output logic                     grant_valid
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [IW-1:0]      last_grant_q;
    logic [IW-1:0]      lock_owner_q;
    logic               lock_valid_q;
    logic [IW-1:0]      scan_idx;
    logic               found;
    logic [MAX_REQ-1:0] grant_wide;

    always_comb begin
        grant    = '0;
        found    = 1'b0;
        scan_idx = '0;
        if (lock_valid_q && req[lock_owner_q]) begin
            grant[lock_owner_q] = 1'b1;
        end else begin
            // Scan starts one past the last winner and wraps.
            for (int unsigned k = 1; k <= NREQ; k++) begin
                scan_idx = IW'((32'(last_grant_q) + k) % NREQ);
                if (!found && req[scan_idx]) begin
                    grant[scan_idx] = 1'b1;
                    found           = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_wide             = '0;
        grant_wide[NREQ-1:0]   = grant;
    end

    assign grant_idx   = IW'(onehot_to_idx(grant_wide));
    assign grant_valid = |grant;

    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            last_grant_q <= IW'(NREQ - 1);
            lock_owner_q <= '0;
            lock_valid_q <= 1'b0;
        end else if (grant_valid) begin
            last_grant_q <= grant_idx;
            lock_owner_q <= grant_idx;
            lock_valid_q <= lock[grant_idx];
        end else begin
            lock_valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between NREQ requesters; reads return one cycle after acceptance.
// Define RAM_ARB_BOUNDS_EN to reject accesses at or above DEPTH with rsp_err.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned AW    = RAM_AW,
    parameter int unsigned DW    = RAM_DW,
    parameter int unsigned DEPTH = RAM_DEPTH
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*DW-1:0]       req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [DW-1:0]            rsp_data,
    output logic                     rsp_err,
    output logic [AW-1:0]            ram_addr,
    output logic [DW-1:0]            ram_din,
    output logic                     ram_wen,
    output logic                     ram_ren,
    input  logic [DW-1:0]            ram_dout
);

    localparam int unsigned IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > MAX_REQ || 64'(DEPTH) > (64'd1 << AW)) begin : g_bad_params
        $error("ram_port_arbiter: unsupported parameter combination");
    end

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_valid;
    logic [IW-1:0]   sel_q;
    logic [IW-1:0]   sel;
    logic            oob;
    logic            read_pending_q;
    logic [IW-1:0]   rsp_id_q;
    ram_op_t         op;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk         (clk),
        .nRST        (nRST),
        .req         (req_valid),
        .lock        (req_lock),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign req_ready = grant;

    // Idle cycles keep the previous select so the RAM address bus does not toggle.
    assign sel = grant_valid ? grant_idx : sel_q;

    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel == IW'(i)) begin
                ram_addr = req_addr[i*AW +: AW];
                ram_din  = req_wdata[i*DW +: DW];
            end
        end
    end

    assign op      = req_we[grant_idx] ? OP_WRITE : OP_READ;
    assign ram_wen = grant_valid && (op == OP_WRITE) && !oob;
    assign ram_ren = grant_valid && (op == OP_READ) && !oob;

    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            sel_q          <= '0;
            read_pending_q <= 1'b0;
            rsp_id_q       <= '0;
        end else begin
            read_pending_q <= ram_ren;
            if (grant_valid) begin
                sel_q    <= grant_idx;
                rsp_id_q <= grant_idx;
            end
        end
    end

`ifdef RAM_ARB_BOUNDS_EN
    logic err_q;

    assign oob = grant_valid && (32'(ram_addr) >= DEPTH);

    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= oob;
        end
    end

    assign rsp_err = err_q;
`else
    assign oob     = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign rsp_valid = read_pending_q | rsp_err;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = read_pending_q ? ram_dout : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural RAM and arbitration model.
module tb_ram_port_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int unsigned DEPTH = 37500;
`ifdef RAM_ARB_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic               clk;
    logic               nRST;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic [1:0]         rsp_id;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_din;
    logic               ram_wen;
    logic               ram_ren;
    logic [DW-1:0]      ram_dout;

    ram_port_arbiter #(
        .NREQ  (NREQ),
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .nRST      (nRST),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_wen   (ram_wen),
        .ram_ren   (ram_ren),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input int unsigned a);
        return {16'(a) ^ 16'h5A5A, ~16'(a)};
    endfunction

    // Behavioural RAM: unwritten words read as pattern(addr).
    logic [31:0] mem     [65536];
    bit          mem_vld [65536];
    always @(posedge clk) begin
        if (ram_wen) begin
            mem[ram_addr]     <= ram_din;
            mem_vld[ram_addr] <= 1'b1;
        end
        if (ram_ren) begin
            ram_dout <= mem_vld[ram_addr] ? mem[ram_addr] : pattern(32'(ram_addr));
        end
    end

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state
    int          m_last = NREQ - 1;
    int          m_lock = -1;
    logic [31:0] ref_wr [int unsigned];
    logic [15:0] s_addr  [NREQ];
    logic [31:0] s_wdata [NREQ];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Monitor: every response must appear exactly one cycle after its acceptance.
    always @(negedge clk) begin
        rsp_t e;
        check("rsp_valid", rsp_valid, sb.size() > 0);
        if (rsp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_id", rsp_id, e.id);
            check("rsp_data", rsp_data, e.data);
            check("rsp_err", rsp_err, e.err);
        end else if (!rsp_valid) begin
            check("rsp_data_gated", rsp_data, 0);
            sb.delete();
        end
    end

    task automatic step(input logic [3:0] v, input logic [3:0] we, input logic [3:0] lk,
                        output int got);
        int          exp_g;
        int unsigned a;
        bit          oob;
        bit          is_wr;
        rsp_t        r;
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_lock  = lk;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = s_addr[i];
            req_wdata[i*DW +: DW] = s_wdata[i];
        end
        #1;
        exp_g = -1;
        if (m_lock >= 0 && v[m_lock]) begin
            exp_g = m_lock;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                if (exp_g < 0 && v[(m_last + k) % NREQ]) exp_g = (m_last + k) % NREQ;
            end
        end
        got = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) got = (got == -1) ? i : -2;
        end
        check("req_ready", req_ready, (exp_g >= 0) ? (4'b0001 << exp_g) : 4'b0000);
        if (exp_g >= 0) begin
            a     = 32'(s_addr[exp_g]);
            oob   = BOUNDS && (a >= DEPTH);
            is_wr = we[exp_g];
            check("ram_wen", ram_wen, is_wr && !oob);
            check("ram_ren", ram_ren, !is_wr && !oob);
            check("ram_addr", ram_addr, a);
            if (is_wr && !oob) begin
                check("ram_din", ram_din, s_wdata[exp_g]);
                ref_wr[a] = s_wdata[exp_g];
            end
            if (oob) begin
                r.id = exp_g; r.data = 32'h0; r.err = 1'b1;
                sb.push_back(r);
            end else if (!is_wr) begin
                r.id   = exp_g;
                r.data = ref_wr.exists(a) ? ref_wr[a] : pattern(a);
                r.err  = 1'b0;
                sb.push_back(r);
            end
            m_last = exp_g;
            m_lock = lk[exp_g] ? exp_g : -1;
        end else begin
            check("idle_wen", ram_wen, 0);
            check("idle_ren", ram_ren, 0);
            m_lock = -1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        nRST = 1'b1;
        req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            s_addr[i] = '0; s_wdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_wen_ren", {ram_wen, ram_ren}, 0);
        nRST = 1'b0;

        // All four requesters reading, held high: strict rotation from 0.
        for (int i = 0; i < NREQ; i++) s_addr[i] = 16'((i + 1) * 16);
        for (int i = 0; i < 5; i++) begin
            step(4'hF, 4'h0, 4'h0, got);
            check("rr_order", got, i % NREQ);
        end

        // Write then read-back through a different requester.
        s_addr[2] = 16'h0100; s_wdata[2] = 32'hDEADBEEF;
        step(4'b0100, 4'b0100, 4'h0, got);
        check("wr_grant", got, 2);
        s_addr[1] = 16'h0100;
        step(4'b0010, 4'b0000, 4'h0, got);
        check("rd_grant", got, 1);
        @(posedge clk); #1;
        check("wr_rd_id", rsp_id, 1);
        check("wr_rd_data", rsp_data, 32'hDEADBEEF);

        // Lock holds requester 1 for five cycles, then rotation resumes at 3, 0.
        step(4'b0010, 4'b0000, 4'b0010, got);
        check("lock_first", got, 1);
        for (int i = 0; i < 4; i++) begin
            step(4'b1011, 4'b0000, 4'b0010, got);
            check("lock_hold", got, 1);
        end
        step(4'b1001, 4'b0000, 4'b0000, got);
        check("lock_after0", got, 3);
        step(4'b1001, 4'b0000, 4'b0000, got);
        check("lock_after1", got, 0);

        // Idle window leaves the rotation pointer untouched.
        for (int i = 0; i < 10; i++) begin
            step(4'h0, 4'h0, 4'h0, got);
            check("idle_grant", got, -1);
        end
        step(4'hF, 4'h0, 4'h0, got);
        check("idle_resume", got, 1);

        // Out-of-range address handling.
        s_addr[3] = 16'(DEPTH);
        step(4'b1000, 4'b0000, 4'h0, got);
        check("oob_grant", got, 3);
        @(posedge clk); #1;
        check("oob_rsp_err", rsp_err, BOUNDS);
        check("oob_rsp_id", rsp_id, 3);
        check("oob_rsp_data", rsp_data, BOUNDS ? 32'h0 : pattern(DEPTH));

        // Reset right after a read is accepted drops the response.
        s_addr[0] = 16'h0055;
        step(4'b0001, 4'b0000, 4'h0, got);
        check("pre_rst_grant", got, 0);
        @(posedge clk); #1;
        nRST = 1'b1;
        req_valid = '0;
        sb.delete();
        m_last = NREQ - 1;
        m_lock = -1;
        @(negedge clk); #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_id", rsp_id, 0);
        check("mid_rst_ready", req_ready, 0);
        @(negedge clk);
        nRST = 1'b0;
        step(4'hF, 4'h0, 4'h0, got);
        check("post_rst_grant", got, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] v, we, lk;
            for (int i = 0; i < NREQ; i++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r == 0) s_addr[i] = 16'(DEPTH - 1);
                else if (r == 1) s_addr[i] = 16'(DEPTH);
                else if (r == 2) s_addr[i] = 16'hFFFF;
                else s_addr[i] = 16'($urandom_range(0, 31));
                s_wdata[i] = $urandom;
                lk[i] = ($urandom_range(0, 7) == 0);
            end
            v  = 4'($urandom);
            we = 4'($urandom);
            step(v, we, lk, got);
        end

        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
